// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - decode/hazard to fetch control bundle
//
// Requests (driven by decode/hazard logic):
//   hazard, br_req, br_off, jmp_req, jmp_tgt, halt_req, resume
// Controls and status (driven by fetch_redirect_ctrl):
//   brTaken, jump_en, brOffset, freeze, flush, halted, stall_cnt, timeout
interface fetch_redirect_ctrl_if #(
    parameter int WORD_LEN = 16
);
    logic                hazard;
    logic                br_req;
    logic [WORD_LEN-1:0] br_off;
    logic                jmp_req;
    logic [WORD_LEN-1:0] jmp_tgt;
    logic                halt_req;
    logic                resume;

    logic                brTaken;
    logic                jump_en;
    logic [WORD_LEN-1:0] brOffset;
    logic                freeze;
    logic                flush;
    logic                halted;
    logic [7:0]          stall_cnt;
    logic                timeout;

    modport master (
        output hazard, br_req, br_off, jmp_req, jmp_tgt, halt_req, resume,
        input  brTaken, jump_en, brOffset, freeze, flush, halted, stall_cnt, timeout
    );

    modport slave (
        input  hazard, br_req, br_off, jmp_req, jmp_tgt, halt_req, resume,
        output brTaken, jump_en, brOffset, freeze, flush, halted, stall_cnt, timeout
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch-stage redirect, stall and halt sequencer
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - fetch_redirect_ctrl_if.slave: requests in, fetch controls/status out
// brTaken/jump_en/brOffset/freeze are combinational (zero-cycle redirect);
// flush/halted/stall_cnt/timeout are registered.
module fetch_redirect_ctrl #(
    parameter int WORD_LEN     = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_LIMIT  = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_redirect_ctrl_if.slave  bus
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);
    localparam logic [7:0] STALL_LIM  = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          flush_cnt_q, flush_cnt_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;
    logic [7:0]          stall_cnt_q, stall_cnt_d;
    logic                timeout_q, timeout_d;

    logic                br_taken_c;
    logic                jump_en_c;
    logic [WORD_LEN-1:0] br_offset_c;
    logic                freeze_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = 8'd0;         // any non-hazard cycle or non-RUN state clears it
        timeout_d   = timeout_q;
        br_taken_c  = 1'b0;
        jump_en_c   = 1'b0;
        br_offset_c = '0;
        freeze_c    = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.hazard) begin
                    // Unresolved instruction in ID: hold PC, ignore its requests.
                    freeze_c    = 1'b1;
                    stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
                end else if (bus.jmp_req) begin
                    jump_en_c   = 1'b1;
                    br_offset_c = bus.jmp_tgt;
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end else if (bus.br_req) begin
                    br_taken_c  = 1'b1;
                    br_offset_c = bus.br_off;
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end else if (bus.halt_req) begin
                    freeze_c    = 1'b1;
                    state_d     = HALT;
                end
            end
            FLUSH: begin
                // Requests here come from killed wrong-path instructions.
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_d == 2'd0) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                freeze_c = 1'b1;
                if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (stall_cnt_d == STALL_LIM) begin
            timeout_d = 1'b1;
        end
    end

    // Registered status follows the next state so flush covers exactly the
    // FLUSH_CYCLES cycles after the redirect edge and halted drops on resume.
    assign flush_d  = (state_d == FLUSH);
    assign halted_d = (state_d == HALT);

    // Combinational controls are forced quiet while reset is held.
    assign bus.brTaken   = rst & br_taken_c;
    assign bus.jump_en   = rst & jump_en_c;
    assign bus.freeze    = rst & freeze_c;
    assign bus.brOffset  = rst ? br_offset_c : '0;
    assign bus.flush     = flush_q;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.WORD_LEN(16)) bus ();

    fetch_redirect_ctrl #(
        .WORD_LEN    (16),
        .FLUSH_CYCLES(1),
        .STALL_LIMIT (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.hazard   = 1'b0;
        bus.br_req   = 1'b0;
        bus.jmp_req  = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
    endtask

    initial begin
        clear_reqs();
        bus.br_off  = 16'h0000;
        bus.jmp_tgt = 16'h0000;

        // Reset held with requests active
        rst         = 1'b0;
        bus.br_req  = 1'b1;
        bus.hazard  = 1'b1;
        bus.br_off  = 16'hFFFC;
        tick();
        tick();
        check_eq("rst_brTaken", bus.brTaken, 0);
        check_eq("rst_jump_en", bus.jump_en, 0);
        check_eq("rst_freeze", bus.freeze, 0);
        check_eq("rst_flush", bus.flush, 0);
        check_eq("rst_brOffset", bus.brOffset, 0);
        check_eq("rst_stall_cnt", bus.stall_cnt, 0);
        check_eq("rst_timeout", bus.timeout, 0);
        check_eq("rst_halted", bus.halted, 0);

        // Release, no requests: sequential fetch
        clear_reqs();
        rst = 1'b1;
        #1;
        check_eq("seq_brTaken", bus.brTaken, 0);
        check_eq("seq_freeze", bus.freeze, 0);
        tick();
        check_eq("seq_flush", bus.flush, 0);
        check_eq("seq_stall_cnt", bus.stall_cnt, 0);

        // Taken branch with negative offset
        bus.br_req = 1'b1;
        bus.br_off = 16'hFFFC;
        #1;
        check_eq("br_brTaken", bus.brTaken, 1);
        check_eq("br_brOffset", bus.brOffset, 16'hFFFC);
        check_eq("br_jump_en", bus.jump_en, 0);
        check_eq("br_freeze", bus.freeze, 0);
        tick();
        bus.hazard = 1'b1;
        #1;
        check_eq("brfl_flush", bus.flush, 1);
        check_eq("brfl_brTaken_masked", bus.brTaken, 0);
        check_eq("brfl_freeze_masked", bus.freeze, 0);
        clear_reqs();
        tick();
        check_eq("brfl_flush_end", bus.flush, 0);
        check_eq("brfl_stall_cnt", bus.stall_cnt, 0);

        // Jump and branch together: jump wins
        bus.jmp_req = 1'b1;
        bus.jmp_tgt = 16'h0040;
        bus.br_req  = 1'b1;
        bus.br_off  = 16'h1234;
        #1;
        check_eq("jb_jump_en", bus.jump_en, 1);
        check_eq("jb_brTaken", bus.brTaken, 0);
        check_eq("jb_brOffset", bus.brOffset, 16'h0040);
        tick();
        clear_reqs();
        check_eq("jb_flush", bus.flush, 1);
        tick();
        check_eq("jb_flush_end", bus.flush, 0);

        // Hazard masks a pending branch, counting stall cycles
        bus.hazard   = 1'b1;
        bus.br_req   = 1'b1;
        bus.halt_req = 1'b1;
        bus.br_off   = 16'h0008;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_eq("hz_freeze", bus.freeze, 1);
            check_eq("hz_brTaken", bus.brTaken, 0);
            check_eq("hz_brOffset", bus.brOffset, 0);
            tick();
            check_eq("hz_stall_cnt", bus.stall_cnt, i);
        end
        bus.hazard = 1'b0;
        #1;
        check_eq("hzr_brTaken", bus.brTaken, 1);
        check_eq("hzr_freeze", bus.freeze, 0);
        check_eq("hzr_brOffset", bus.brOffset, 16'h0008);
        tick();
        clear_reqs();
        check_eq("hzr_stall_cnt", bus.stall_cnt, 0);
        check_eq("hzr_flush", bus.flush, 1);
        check_eq("hzr_halted", bus.halted, 0);
        tick();

        // Stall timeout at STALL_LIMIT=5
        bus.hazard = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq("to_stall_cnt", bus.stall_cnt, k);
            check_eq("to_timeout", bus.timeout, (k >= 5) ? 1 : 0);
        end
        bus.hazard = 1'b0;
        tick();
        check_eq("to_stall_clr", bus.stall_cnt, 0);
        check_eq("to_sticky", bus.timeout, 1);

        // Halt, masked jump, resume
        bus.halt_req = 1'b1;
        #1;
        check_eq("ht_freeze", bus.freeze, 1);
        tick();
        bus.halt_req = 1'b0;
        bus.jmp_req  = 1'b1;
        bus.jmp_tgt  = 16'h0055;
        #1;
        check_eq("ht_halted", bus.halted, 1);
        check_eq("ht_freeze_hold", bus.freeze, 1);
        check_eq("ht_jump_masked", bus.jump_en, 0);
        check_eq("ht_brOffset", bus.brOffset, 0);
        tick();
        bus.jmp_req = 1'b0;
        check_eq("ht_still_halted", bus.halted, 1);
        check_eq("ht_no_flush", bus.flush, 0);
        bus.resume = 1'b1;
        #1;
        check_eq("ht_resume_pending", bus.halted, 1);
        tick();
        bus.resume = 1'b0;
        #1;
        check_eq("rs_halted", bus.halted, 0);
        check_eq("rs_freeze", bus.freeze, 0);
        check_eq("rs_flush", bus.flush, 0);

        // Halt again, reset pulsed mid-HALT
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_eq("hr_halted", bus.halted, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("hr_halted_async", bus.halted, 0);
        check_eq("hr_freeze", bus.freeze, 0);
        check_eq("hr_timeout_clr", bus.timeout, 0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("hr_run_halted", bus.halted, 0);
        check_eq("hr_run_freeze", bus.freeze, 0);
        check_eq("hr_run_flush", bus.flush, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
